sram_wb_port_ctrl: RTL and testbench

- Wishbone-classic slave that initiates every access on the single RW port of the 1024×33 sky130 SRAM macro: `csb0`, `web0`, `wmask0`, `spare_wen0`, `addr0`, `din0`, `dout0`.
- Uses bit 32 (spare bit) as even parity over data[31:0].
- Partial-byte writes become read-modify-write, so parity is never stale.
- Sits between the Caravel management Wishbone and the SRAM macro in the user project area.

---
 rtl/sram_ctrl_pkg.sv | 23 ++
 rtl/sram_rmw_merge.sv | 22 ++
 rtl/sram_wb_port_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_sram_wb_port_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the Wishbone-to-sky130 SRAM port controller.
// Bit 32 of each stored word holds even parity over bits 31:0.
package sram_ctrl_pkg;

  localparam int        DATA_W      = 32;
  localparam int        PAR_BIT     = 32;
  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_CAPT  = 3'd2,
    RMW_WR   = 3'd3,
    WR_DONE  = 3'd4,
    ACK_GAP  = 3'd5
  } state_t;

  // XOR over all 33 bits: 0 for a consistent stored word, 1 for a parity error.
  function automatic logic par33(input logic [DATA_W:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/sram_rmw_merge.sv
// Byte merge of new write data over an existing word, producing the full
// 33-bit SRAM word with freshly generated parity in bit 32.
module sram_rmw_merge
  import sram_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] old_data,
  input  logic [DATA_W-1:0] new_data,
  input  logic [3:0]        sel,
  output logic [DATA_W:0]   word
);

  logic [DATA_W-1:0] merged;

  always_comb begin
    merged = old_data;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) merged[8*b +: 8] = new_data[8*b +: 8];
    end
    word = {par33({1'b0, merged}), merged};
  end

endmodule

// File: rtl/sram_wb_port_ctrl.sv
// Wishbone-classic slave driving the single RW port of the 1024x33 SRAM macro,
// with parity on the spare bit and read-modify-write for partial-byte writes.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for a request; issues the first SRAM access
// RD_ISSUE | macro is capturing the read; chip select released
// RD_CAPT  | read data valid: capture, parity check, ack or issue RMW write
// RMW_WR   | merged full-word write in flight; ack the master
// WR_DONE  | write (or sel==0 no-op) issued; ack the master
// ACK_GAP  | ack low for one cycle so the held stb is not re-sampled
module sram_wb_port_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          ADDR_WIDTH = 10
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [3:0]            sram_wmask0,
  output logic                  sram_spare_wen0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [32:0]           sram_din0,
  input  logic [32:0]           sram_dout0,
  output logic                  parity_err_o,
  output logic [7:0]            err_cnt_o,
  output logic [ADDR_WIDTH-1:0] err_addr_o,
  input  logic                  err_clr_i
);

  state_t state_q, state_d;

  logic                  hit, req, take_req;
  logic                  full_wr, partial_wr;
  logic                  rmw_q;
  logic [DATA_W-1:0]     wr_dat_q;
  logic [3:0]            wr_sel_q;
  logic [DATA_W-1:0]     mrg_dat;
  logic [3:0]            mrg_sel;
  logic [DATA_W:0]       mrg_word;

  logic                  csb_d, web_d, spare_d, ack_d, rd_load;
  logic [3:0]            wmask_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [32:0]           din_d;
  logic                  err_event;

  logic unused_adr;
  assign unused_adr = ^wbs_adr_i[1:0];

  assign hit        = (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
  assign req        = wbs_cyc_i & wbs_stb_i & hit;
  assign take_req   = (state_q == IDLE) & req;
  assign full_wr    = wbs_we_i & (wbs_sel_i == 4'hF);
  assign partial_wr = wbs_we_i & (wbs_sel_i != 4'h0) & (wbs_sel_i != 4'hF);

  // In IDLE the live bus data feeds the merge; later phases use the latched copy
  // so a master dropping cyc mid-RMW cannot corrupt the word being written.
  assign mrg_dat = take_req ? wbs_dat_i : wr_dat_q;
  assign mrg_sel = take_req ? wbs_sel_i : wr_sel_q;

  sram_rmw_merge u_merge (
    .old_data (sram_dout0[DATA_W-1:0]),
    .new_data (mrg_dat),
    .sel      (mrg_sel),
    .word     (mrg_word)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    csb_d   = 1'b1;
    web_d   = 1'b1;
    wmask_d = 4'h0;
    spare_d = 1'b0;
    addr_d  = sram_addr0;
    din_d   = sram_din0;
    ack_d   = 1'b0;
    rd_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d = wbs_adr_i[ADDR_WIDTH+1:2];
          if (full_wr) begin
            csb_d   = 1'b0;
            web_d   = 1'b0;
            wmask_d = 4'hF;
            spare_d = 1'b1;
            din_d   = mrg_word;
            state_d = WR_DONE;
          end else if (!wbs_we_i || partial_wr) begin
            csb_d   = 1'b0;
            state_d = RD_ISSUE;
          end else begin
            state_d = WR_DONE;
          end
        end
      end
      RD_ISSUE: state_d = RD_CAPT;
      RD_CAPT: begin
        // Merge straight off dout so the RMW write is issued on the capture edge.
        if (rmw_q) begin
          csb_d   = 1'b0;
          web_d   = 1'b0;
          wmask_d = 4'hF;
          spare_d = 1'b1;
          din_d   = mrg_word;
          state_d = RMW_WR;
        end else begin
          rd_load = 1'b1;
          ack_d   = 1'b1;
          state_d = ACK_GAP;
        end
      end
      RMW_WR: begin
        ack_d   = 1'b1;
        state_d = ACK_GAP;
      end
      WR_DONE: begin
        ack_d   = 1'b1;
        state_d = ACK_GAP;
      end
      ACK_GAP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sram_csb0       <= 1'b1;
      sram_web0       <= 1'b1;
      sram_wmask0     <= 4'h0;
      sram_spare_wen0 <= 1'b0;
      sram_addr0      <= '0;
      sram_din0       <= '0;
      wbs_ack_o       <= 1'b0;
      wbs_dat_o       <= '0;
    end else begin
      sram_csb0       <= csb_d;
      sram_web0       <= web_d;
      sram_wmask0     <= wmask_d;
      sram_spare_wen0 <= spare_d;
      sram_addr0      <= addr_d;
      sram_din0       <= din_d;
      wbs_ack_o       <= ack_d & wbs_cyc_i;
      if (rd_load) wbs_dat_o <= sram_dout0[DATA_W-1:0];
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rmw_q    <= 1'b0;
      wr_dat_q <= '0;
      wr_sel_q <= 4'h0;
    end else if (take_req) begin
      rmw_q    <= partial_wr;
      wr_dat_q <= wbs_dat_i;
      wr_sel_q <= wbs_sel_i;
    end
  end

  assign err_event = (state_q == RD_CAPT) & par33(sram_dout0);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      parity_err_o <= 1'b0;
      err_cnt_o    <= 8'h00;
      err_addr_o   <= '0;
    end else if (err_clr_i) begin
      parity_err_o <= 1'b0;
      err_cnt_o    <= 8'h00;
      err_addr_o   <= '0;
    end else if (err_event) begin
      parity_err_o <= 1'b1;
      if (err_cnt_o != ERR_CNT_MAX) err_cnt_o <= err_cnt_o + 8'd1;
      err_addr_o   <= sram_addr0;
    end
  end

endmodule

// File: tb/tb_sram_wb_port_ctrl.sv
// Directed bench for sram_wb_port_ctrl with a behavioural 1024x33 SRAM model
// that registers reads on the capture edge and drives X one cycle later.
module tb_sram_wb_port_ctrl;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        sram_csb0, sram_web0, sram_spare_wen0;
  logic [3:0]  sram_wmask0;
  logic [9:0]  sram_addr0;
  logic [32:0] sram_din0;
  logic [32:0] sram_dout0;
  logic        parity_err_o;
  logic [7:0]  err_cnt_o;
  logic [9:0]  err_addr_o;
  logic        err_clr_i;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  sram_wb_port_ctrl dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_spare_wen0(sram_spare_wen0), .sram_addr0(sram_addr0),
    .sram_din0(sram_din0), .sram_dout0(sram_dout0),
    .parity_err_o(parity_err_o), .err_cnt_o(err_cnt_o), .err_addr_o(err_addr_o),
    .err_clr_i(err_clr_i)
  );

  // SRAM model with a backdoor port for preloading words.
  logic [32:0] mem [0:1023];
  logic        rd_pend = 1'b0;
  logic        bd_we = 1'b0;
  logic [9:0]  bd_addr = '0;
  logic [32:0] bd_data = '0;

  always @(posedge wb_clk_i) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    if (!sram_csb0) begin
      if (!sram_web0) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask0[b]) mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
        if (sram_spare_wen0) mem[sram_addr0][32] <= sram_din0[32];
        rd_pend <= 1'b0;
      end else begin
        sram_dout0 <= mem[sram_addr0];
        rd_pend    <= 1'b1;
      end
    end else if (rd_pend) begin
      sram_dout0 <= 'x;
      rd_pend    <= 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [32:0] good_word(input logic [31:0] d);
    return {^d, d};
  endfunction

  task automatic preload(input int a, input logic [32:0] w);
    @(negedge wb_clk_i);
    bd_we = 1'b1; bd_addr = a[9:0]; bd_data = w;
    @(posedge wb_clk_i); #1;
    bd_we = 1'b0;
  endtask

  // Runs one Wishbone cycle; ack_edge counts edges after E0 (-1 = no ack).
  task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                         input logic [31:0] dat, output int ack_edge,
                         output logic [31:0] rdata, output int nacc,
                         output logic [32:0] wdin, output logic [3:0] wmsk);
    ack_edge = -1; nacc = 0; rdata = '0; wdin = '0; wmsk = '0;
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_sel_i = sel; wbs_adr_i = adr; wbs_dat_i = dat;
    for (int i = 0; i < 10; i++) begin
      @(posedge wb_clk_i); #1;
      if (!sram_csb0) begin
        nacc++;
        if (!sram_web0) begin wdin = sram_din0; wmsk = sram_wmask0; end
      end
      if (wbs_ack_o) begin ack_edge = i; rdata = wbs_dat_o; break; end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wbs_sel_i = 4'h0;
    for (int i = 0; i < 2; i++) begin
      @(posedge wb_clk_i); #1;
      if (!sram_csb0) nacc++;
      if (wbs_ack_o) ack_edge = 100;
    end
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1; err_clr_i = 1'b0;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0;
    wbs_adr_i = '0; wbs_dat_i = '0;
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i); wb_rst_i = 1'b0;
    #1;
    vec_cnt++;
    if ({sram_csb0, sram_web0, sram_wmask0, sram_spare_wen0} !== 7'b1100000) begin
      err_cnt++;
      $display("FAIL reset_ctrl: got csb=%b web=%b wmask=%h spare=%b, want 1 1 0 0",
               sram_csb0, sram_web0, sram_wmask0, sram_spare_wen0);
    end
    vec_cnt++;
    if (sram_addr0 !== 10'd0 || sram_din0 !== 33'd0) begin
      err_cnt++;
      $display("FAIL reset_addr_din: got addr=%h din=%h, want 0 0", sram_addr0, sram_din0);
    end
    vec_cnt++;
    if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'd0) begin
      err_cnt++;
      $display("FAIL reset_wb: got ack=%b dat=%h, want 0 0", wbs_ack_o, wbs_dat_o);
    end
    vec_cnt++;
    if (parity_err_o !== 1'b0 || err_cnt_o !== 8'd0 || err_addr_o !== 10'd0) begin
      err_cnt++;
      $display("FAIL reset_status: got perr=%b cnt=%0d addr=%0d, want 0 0 0",
               parity_err_o, err_cnt_o, err_addr_o);
    end
  endtask

  task automatic test_full_write_read();
    int ae, na; logic [31:0] rd; logic [32:0] wd; logic [3:0] wm;
    preload(4, 33'h1_0000_0000);
    wb_xfer(32'h3000_0010, 1'b1, 4'hF, 32'hDEADBEEF, ae, rd, na, wd, wm);
    vec_cnt++;
    if (ae !== 1 || na !== 1) begin
      err_cnt++;
      $display("FAIL full_wr_timing: got ack_edge=%0d accesses=%0d, want 1 1", ae, na);
    end
    vec_cnt++;
    if (wd !== good_word(32'hDEADBEEF) || wm !== 4'hF) begin
      err_cnt++;
      $display("FAIL full_wr_din: got din=%h wmask=%h, want %h F", wd, wm, good_word(32'hDEADBEEF));
    end
    vec_cnt++;
    if (mem[4] !== good_word(32'hDEADBEEF)) begin
      err_cnt++;
      $display("FAIL full_wr_mem: got %h, want %h", mem[4], good_word(32'hDEADBEEF));
    end
    wb_xfer(32'h3000_0010, 1'b0, 4'hF, 32'h0, ae, rd, na, wd, wm);
    vec_cnt++;
    if (ae !== 2 || na !== 1) begin
      err_cnt++;
      $display("FAIL read_timing: got ack_edge=%0d accesses=%0d, want 2 1", ae, na);
    end
    vec_cnt++;
    if (rd !== 32'hDEADBEEF || parity_err_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL read_data: got dat=%h perr=%b, want deadbeef 0", rd, parity_err_o);
    end
  endtask

  task automatic test_partial_write();
    int ae, na; logic [31:0] rd; logic [32:0] wd; logic [3:0] wm;
    preload(8, good_word(32'h11223344));
    wb_xfer(32'h3000_0020, 1'b1, 4'b0101, 32'hAABBCCDD, ae, rd, na, wd, wm);
    vec_cnt++;
    if (ae !== 3 || na !== 2) begin
      err_cnt++;
      $display("FAIL rmw_timing: got ack_edge=%0d accesses=%0d, want 3 2", ae, na);
    end
    vec_cnt++;
    if (wd !== good_word(32'h11BB33DD) || wm !== 4'hF) begin
      err_cnt++;
      $display("FAIL rmw_din: got din=%h wmask=%h, want %h F", wd, wm, good_word(32'h11BB33DD));
    end
    vec_cnt++;
    if (mem[8] !== good_word(32'h11BB33DD)) begin
      err_cnt++;
      $display("FAIL rmw_mem: got %h, want %h", mem[8], good_word(32'h11BB33DD));
    end
    preload(10, good_word(32'h0000_0000));
    wb_xfer(32'h3000_0028, 1'b1, 4'b1000, 32'h8000_0000, ae, rd, na, wd, wm);
    vec_cnt++;
    if (mem[10] !== 33'h1_8000_0000) begin
      err_cnt++;
      $display("FAIL rmw_parity_flip: got %h, want 180000000", mem[10]);
    end
  endtask

  task automatic test_parity_error();
    int ae, na; logic [31:0] rd; logic [32:0] wd; logic [3:0] wm;
    preload(5, {~(^32'h0F0F_1234), 32'h0F0F_1234});
    wb_xfer(32'h3000_0014, 1'b0, 4'hF, 32'h0, ae, rd, na, wd, wm);
    vec_cnt++;
    if (ae !== 2 || rd !== 32'h0F0F_1234) begin
      err_cnt++;
      $display("FAIL perr_read: got ack_edge=%0d dat=%h, want 2 0f0f1234", ae, rd);
    end
    vec_cnt++;
    if (parity_err_o !== 1'b1 || err_cnt_o !== 8'd1 || err_addr_o !== 10'd5) begin
      err_cnt++;
      $display("FAIL perr_status: got perr=%b cnt=%0d addr=%0d, want 1 1 5",
               parity_err_o, err_cnt_o, err_addr_o);
    end
    for (int k = 0; k < 299; k++)
      wb_xfer(32'h3000_0014, 1'b0, 4'hF, 32'h0, ae, rd, na, wd, wm);
    vec_cnt++;
    if (err_cnt_o !== 8'd255 || parity_err_o !== 1'b1) begin
      err_cnt++;
      $display("FAIL perr_saturate: got cnt=%0d perr=%b, want 255 1", err_cnt_o, parity_err_o);
    end
  endtask

  task automatic test_err_clr_priority();
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_sel_i = 4'hF; wbs_adr_i = 32'h3000_0014;
    @(posedge wb_clk_i);
    @(posedge wb_clk_i);
    @(negedge wb_clk_i); err_clr_i = 1'b1;
    @(posedge wb_clk_i); #1; err_clr_i = 1'b0;
    vec_cnt++;
    if (wbs_ack_o !== 1'b1 || wbs_dat_o !== 32'h0F0F_1234) begin
      err_cnt++;
      $display("FAIL clr_ack: got ack=%b dat=%h, want 1 0f0f1234", wbs_ack_o, wbs_dat_o);
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(posedge wb_clk_i); #1;
    vec_cnt++;
    if (parity_err_o !== 1'b0 || err_cnt_o !== 8'd0 || err_addr_o !== 10'd0) begin
      err_cnt++;
      $display("FAIL clr_priority: got perr=%b cnt=%0d addr=%0d, want 0 0 0",
               parity_err_o, err_cnt_o, err_addr_o);
    end
    @(posedge wb_clk_i); #1;
  endtask

  task automatic test_back_to_back();
    int cs_e [3]; int ak_e [2]; int nc, na, dbl;
    logic prev_low;
    nc = 0; na = 0; dbl = 0; prev_low = 1'b0;
    cs_e = '{-1, -1, -1}; ak_e = '{-1, -1};
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_sel_i = 4'hF; wbs_adr_i = 32'h3000_0010;
    for (int i = 0; i < 10; i++) begin
      @(posedge wb_clk_i); #1;
      if (!sram_csb0) begin
        if (nc < 3) cs_e[nc] = i;
        nc++;
        if (prev_low) dbl++;
      end
      prev_low = !sram_csb0;
      if (wbs_ack_o) begin
        if (na < 2) ak_e[na] = i;
        na++;
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    vec_cnt++;
    if (nc !== 3 || cs_e[0] !== 0 || cs_e[1] !== 4 || cs_e[2] !== 8 || dbl !== 0) begin
      err_cnt++;
      $display("FAIL b2b_access: got n=%0d at %0d,%0d,%0d dbl=%0d, want 3 at 0,4,8 dbl=0",
               nc, cs_e[0], cs_e[1], cs_e[2], dbl);
    end
    vec_cnt++;
    if (na !== 2 || ak_e[0] !== 2 || ak_e[1] !== 6) begin
      err_cnt++;
      $display("FAIL b2b_ack: got n=%0d at %0d,%0d, want 2 at 2,6", na, ak_e[0], ak_e[1]);
    end
    na = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) na++;
    end
    vec_cnt++;
    if (na !== 0) begin
      err_cnt++;
      $display("FAIL ack_gated_by_cyc: got %0d acks after cyc drop, want 0", na);
    end
  endtask

  task automatic test_miss_and_sel0();
    int ae, na; logic [31:0] rd; logic [32:0] wd; logic [3:0] wm;
    wb_xfer(32'h3000_1000, 1'b0, 4'hF, 32'h0, ae, rd, na, wd, wm);
    vec_cnt++;
    if (ae !== -1 || na !== 0) begin
      err_cnt++;
      $display("FAIL addr_miss: got ack_edge=%0d accesses=%0d, want -1 0", ae, na);
    end
    wb_xfer(32'h3000_0010, 1'b1, 4'h0, 32'h1234_5678, ae, rd, na, wd, wm);
    vec_cnt++;
    if (ae !== 1 || na !== 0) begin
      err_cnt++;
      $display("FAIL sel0_write: got ack_edge=%0d accesses=%0d, want 1 0", ae, na);
    end
    vec_cnt++;
    if (mem[4] !== good_word(32'hDEADBEEF)) begin
      err_cnt++;
      $display("FAIL sel0_mem: got %h, want %h", mem[4], good_word(32'hDEADBEEF));
    end
  endtask

  task automatic test_reset_mid_rmw();
    int ae, na, acks; logic [31:0] rd; logic [32:0] wd; logic [3:0] wm;
    preload(9, good_word(32'hCAFE_F00D));
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_sel_i = 4'b0011; wbs_adr_i = 32'h3000_0024; wbs_dat_i = 32'h5555_5555;
    @(posedge wb_clk_i);
    @(posedge wb_clk_i);
    #2 wb_rst_i = 1'b1;
    #1;
    vec_cnt++;
    if (sram_csb0 !== 1'b1 || sram_web0 !== 1'b1 || wbs_ack_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL rst_mid_rmw: got csb=%b web=%b ack=%b, want 1 1 0",
               sram_csb0, sram_web0, wbs_ack_o);
    end
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wbs_sel_i = 4'h0;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o || !sram_csb0) acks++;
    end
    vec_cnt++;
    if (acks !== 0) begin
      err_cnt++;
      $display("FAIL rst_quiet: got %0d cycles with ack or csb activity, want 0", acks);
    end
    wb_xfer(32'h3000_0024, 1'b0, 4'hF, 32'h0, ae, rd, na, wd, wm);
    vec_cnt++;
    if (ae !== 2 || rd !== 32'hCAFE_F00D || na !== 1) begin
      err_cnt++;
      $display("FAIL rst_then_read: got ack_edge=%0d dat=%h acc=%0d, want 2 cafef00d 1",
               ae, rd, na);
    end
    wb_xfer(32'h3000_0020, 1'b0, 4'hF, 32'h0, ae, rd, na, wd, wm);
    vec_cnt++;
    if (ae !== 2 || rd !== 32'h11BB_33DD) begin
      err_cnt++;
      $display("FAIL rst_then_read2: got ack_edge=%0d dat=%h, want 2 11bb33dd", ae, rd);
    end
  endtask

  initial begin
    test_reset();
    test_full_write_read();
    test_partial_write();
    test_parity_error();
    test_err_clr_priority();
    test_back_to_back();
    test_miss_and_sel0();
    test_reset_mid_rmw();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
